// File: rtl/cb_cfg_pkg.sv
// Shared types and default timing for the connection-block configuration write sequencer.
package cb_cfg_pkg;

   localparam int CFG_ADDR_W        = 6;
   localparam int CFG_LEN_W         = 8;
   localparam int CFG_SETUP_CYCLES  = 1;
   localparam int CFG_STROBE_CYCLES = 1;
   localparam int CFG_HOLD_CYCLES   = 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_BIT,
      ST_SETUP,
      ST_STROBE,
      ST_HOLD
   } cfg_state_e;

   typedef logic [CFG_ADDR_W-1:0] cfg_addr_t;
   typedef logic [CFG_LEN_W-1:0]  cfg_len_t;

   // Largest of the three phase lengths, used to size the shared phase timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/cb_cfg_phase_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// Loading N-1 makes expired assert on the N-th cycle of the phase.
module cb_cfg_phase_timer #(
   parameter int CNT_W = 1
) (
   input  logic             prog_clk,
   input  logic             prog_reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] count_q;

   // Count down to zero and park there; a load always wins.
   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - CNT_W'(1);
      end
   end

   assign expired = (count_q == '0);

endmodule

// File: rtl/cb_config_write_sequencer.sv
// Turns a burst command plus a bit stream into timed enable strobes on a
// connection-block configuration port, auto-incrementing the address per bit.
module cb_config_write_sequencer
   import cb_cfg_pkg::*;
#(
   parameter int ADDR_W        = CFG_ADDR_W,
   parameter int LEN_W         = CFG_LEN_W,
   parameter int SETUP_CYCLES  = CFG_SETUP_CYCLES,
   parameter int STROBE_CYCLES = CFG_STROBE_CYCLES,
   parameter int HOLD_CYCLES   = CFG_HOLD_CYCLES
) (
   input  logic              prog_clk,
   input  logic              prog_reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic              bit_valid,
   output logic              bit_ready,
   input  logic              bit_data,
   input  logic              abort,
   output logic              enable,
   output logic [ADDR_W-1:0] address,
   output logic              data_in,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int PH_MAX = max3(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
   localparam int PH_W   = $clog2(PH_MAX + 1);

   localparam logic [PH_W-1:0] SETUP_LD  = PH_W'((SETUP_CYCLES  > 0) ? SETUP_CYCLES  - 1 : 0);
   localparam logic [PH_W-1:0] STROBE_LD = PH_W'((STROBE_CYCLES > 0) ? STROBE_CYCLES - 1 : 0);
   localparam logic [PH_W-1:0] HOLD_LD   = PH_W'((HOLD_CYCLES   > 0) ? HOLD_CYCLES   - 1 : 0);

   cfg_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [ADDR_W-1:0] address_d;
   logic              data_d;
   logic              done_d, err_d;
   logic              phase_end;
   logic              tmr_load, tmr_expired;
   logic [PH_W-1:0]   tmr_val;

   assign cmd_ready = (state_q == ST_IDLE) && prog_reset_n;
   assign bit_ready = (state_q == ST_WAIT_BIT);

   cb_cfg_phase_timer #(
      .CNT_W (PH_W)
   ) u_phase_timer (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .load         (tmr_load),
      .load_val     (tmr_val),
      .expired      (tmr_expired)
   );

   // Next-state, burst bookkeeping and phase-timer reload decisions.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      address_d = address;
      data_d    = data_in;
      done_d    = 1'b0;
      err_d     = 1'b0;
      phase_end = 1'b0;
      tmr_load  = 1'b0;
      tmr_val   = '0;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               addr_d = cmd_addr;
               rem_d  = cmd_len;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_WAIT_BIT;
               end
            end
         end
         ST_WAIT_BIT: begin
            if (bit_valid) begin
               address_d = addr_q;
               data_d    = bit_data;
               state_d   = (SETUP_CYCLES > 0) ? ST_SETUP : ST_STROBE;
            end
         end
         ST_SETUP: begin
            if (tmr_expired) begin
               state_d = ST_STROBE;
            end
         end
         ST_STROBE: begin
            if (tmr_expired) begin
               if (HOLD_CYCLES > 0) begin
                  state_d = ST_HOLD;
               end else begin
                  phase_end = 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (tmr_expired) begin
               phase_end = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (phase_end) begin
         rem_d = rem_q - LEN_W'(1);
         if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end else if (addr_q == '1) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_WAIT_BIT;
         end
      end

      if (abort && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         address_d = address;
         data_d    = data_in;
         done_d    = 1'b1;
         err_d     = 1'b1;
      end

      if ((state_d != state_q) &&
          ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD))) begin
         tmr_load = 1'b1;
         case (state_d)
            ST_SETUP:  tmr_val = SETUP_LD;
            ST_STROBE: tmr_val = STROBE_LD;
            default:   tmr_val = HOLD_LD;
         endcase
      end
   end

   // State and registered port outputs, so enable/address/data_in never glitch.
   always_ff @(posedge prog_clk) begin
      if (!prog_reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         enable  <= 1'b0;
         address <= '0;
         data_in <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         enable  <= (state_d == ST_STROBE);
         address <= address_d;
         data_in <= data_d;
         busy    <= (state_d != ST_IDLE);
         done    <= done_d;
         err     <= err_d;
      end
   end

endmodule

// File: tb/tb_cb_config_write_sequencer.sv
// Directed bench for the configuration write sequencer: table-driven bursts on
// a default-timing instance and a SETUP=0/STROBE=3/HOLD=0 instance, plus
// hand-written reset sequences.
module tb_cb_config_write_sequencer;

   localparam int BUDGET = 100;

   typedef struct {
      bit         sel;
      logic [5:0] addr;
      logic [7:0] len;
      logic [7:0] bits;
      int         gap;
      int         abort_at;
      int         exp_strobes;
      bit         exp_err;
      int         exp_first;
      int         exp_spacing;
      int         exp_width;
      int         exp_done;
   } vec_t;

   logic       prog_clk = 1'b0;
   logic       prog_reset_n;
   logic       cmd_valid;
   logic [5:0] cmd_addr;
   logic [7:0] cmd_len;
   logic       bit_valid;
   logic       bit_data;
   logic       abort;
   bit         sel;

   logic       a_cmd_ready, a_bit_ready, a_enable, a_data_in, a_busy, a_done, a_err;
   logic [5:0] a_address;
   logic       b_cmd_ready, b_bit_ready, b_enable, b_data_in, b_busy, b_done, b_err;
   logic [5:0] b_address;

   logic       cmd_ready_m, bit_ready_m, enable_m, data_in_m, busy_m, done_m, err_m;
   logic [5:0] address_m;

   int         checks = 0;
   int         errors = 0;
   vec_t       vecs[8];
   int         st_cyc[16];
   logic [5:0] st_addr[16];
   logic       st_data[16];
   int         st_w[16];
   bit         seen;

   always #5 prog_clk = ~prog_clk;

   cb_config_write_sequencer u_dut_a (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .cmd_valid    (cmd_valid & ~sel),
      .cmd_ready    (a_cmd_ready),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .bit_valid    (bit_valid),
      .bit_ready    (a_bit_ready),
      .bit_data     (bit_data),
      .abort        (abort),
      .enable       (a_enable),
      .address      (a_address),
      .data_in      (a_data_in),
      .busy         (a_busy),
      .done         (a_done),
      .err          (a_err)
   );

   cb_config_write_sequencer #(
      .SETUP_CYCLES  (0),
      .STROBE_CYCLES (3),
      .HOLD_CYCLES   (0)
   ) u_dut_b (
      .prog_clk     (prog_clk),
      .prog_reset_n (prog_reset_n),
      .cmd_valid    (cmd_valid & sel),
      .cmd_ready    (b_cmd_ready),
      .cmd_addr     (cmd_addr),
      .cmd_len      (cmd_len),
      .bit_valid    (bit_valid),
      .bit_ready    (b_bit_ready),
      .bit_data     (bit_data),
      .abort        (abort),
      .enable       (b_enable),
      .address      (b_address),
      .data_in      (b_data_in),
      .busy         (b_busy),
      .done         (b_done),
      .err          (b_err)
   );

   assign cmd_ready_m = sel ? b_cmd_ready : a_cmd_ready;
   assign bit_ready_m = sel ? b_bit_ready : a_bit_ready;
   assign enable_m    = sel ? b_enable    : a_enable;
   assign address_m   = sel ? b_address   : a_address;
   assign data_in_m   = sel ? b_data_in   : a_data_in;
   assign busy_m      = sel ? b_busy      : a_busy;
   assign done_m      = sel ? b_done      : a_done;
   assign err_m       = sel ? b_err       : a_err;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Runs one burst: issue the command, feed bits (optionally after a gap of
   // bit_ready cycles), record every strobe, optionally abort on a given strobe.
   task automatic applyStimulus(input vec_t v);
      int   bit_idx, ready_cnt, n_st, done_cyc, last;
      bit   prev_en, got_done, unstable, overlap, stray_err, done_en, done_err;
      logic [5:0] done_addr;
      bit_idx = 0; ready_cnt = 0; n_st = 0; done_cyc = -1;
      prev_en = 0; got_done = 0; unstable = 0; overlap = 0; stray_err = 0;
      done_en = 0; done_err = 0; done_addr = '0;
      sel = v.sel;
      @(negedge prog_clk);
      checkOutput("cmd_ready_before_cmd", cmd_ready_m, 1);
      cmd_valid = 1'b1;
      cmd_addr  = v.addr;
      cmd_len   = v.len;
      for (int cyc = 1; cyc <= BUDGET && !got_done; cyc++) begin
         @(negedge prog_clk);
         cmd_valid = 1'b0;
         if (cyc == 1) checkOutput("busy_after_cmd", busy_m, (v.len != 0) ? 1 : 0);
         if (bit_ready_m && enable_m) overlap = 1;
         if (err_m && !done_m) stray_err = 1;
         if (enable_m && !prev_en) begin
            if (n_st < 16) begin
               st_cyc[n_st]  = cyc;
               st_addr[n_st] = address_m;
               st_data[n_st] = data_in_m;
               st_w[n_st]    = 0;
            end
            n_st++;
            if (v.abort_at != 0 && n_st == v.abort_at) abort = 1'b1;
         end
         if (enable_m && n_st > 0 && n_st <= 16) begin
            st_w[n_st-1]++;
            if (address_m != st_addr[n_st-1] || data_in_m != st_data[n_st-1]) unstable = 1;
         end
         prev_en = enable_m;
         if (done_m) begin
            got_done  = 1;
            done_cyc  = cyc;
            done_err  = err_m;
            done_en   = enable_m;
            done_addr = address_m;
         end else begin
            if (bit_ready_m) ready_cnt++;
            if (bit_idx < 8) bit_data = v.bits[bit_idx];
            bit_valid = bit_ready_m && (ready_cnt > v.gap) && (bit_idx < int'(v.len));
            if (bit_valid) begin
               bit_idx++;
               ready_cnt = 0;
            end
         end
      end
      abort     = 1'b0;
      bit_valid = 1'b0;
      if (!got_done) checkOutput("done_timeout", 0, 1);
      checkOutput("strobe_count", n_st, v.exp_strobes);
      for (int i = 0; i < n_st && i < v.exp_strobes && i < 16; i++) begin
         checkOutput($sformatf("strobe%0d_addr", i), st_addr[i], 6'(v.addr + 6'(i)));
         checkOutput($sformatf("strobe%0d_data", i), st_data[i], v.bits[i]);
         checkOutput($sformatf("strobe%0d_width", i), st_w[i], v.exp_width);
         if (i == 0) checkOutput("first_strobe_cycle", st_cyc[0], v.exp_first);
         else checkOutput($sformatf("strobe%0d_spacing", i), st_cyc[i] - st_cyc[i-1], v.exp_spacing);
      end
      if (got_done) begin
         checkOutput("err_at_done", done_err, v.exp_err);
         checkOutput("enable_at_done", done_en, 0);
         if (v.exp_strobes == 0) begin
            checkOutput("done_cycle", done_cyc, v.exp_done);
         end else if (n_st > 0) begin
            last = (n_st <= 16) ? n_st - 1 : 15;
            checkOutput("done_after_last_strobe", done_cyc - st_cyc[last], v.exp_done);
            checkOutput("address_at_done", done_addr, 6'(v.addr + 6'(v.exp_strobes - 1)));
         end
      end
      checkOutput("addr_data_stable_in_strobe", unstable, 0);
      checkOutput("bit_ready_during_strobe", overlap, 0);
      checkOutput("err_without_done", stray_err, 0);
      @(negedge prog_clk);
      checkOutput("done_single_pulse", done_m, 0);
      checkOutput("err_single_pulse", err_m, 0);
      checkOutput("busy_after_done", busy_m, 0);
      checkOutput("cmd_ready_after_done", cmd_ready_m, 1);
   endtask

   initial begin
      vecs[0] = '{1'b0, 6'h18, 8'd3, 8'b0000_0101, 0, 0, 3, 1'b0, 3, 4, 1, 2};
      vecs[1] = '{1'b0, 6'h00, 8'd0, 8'b0000_0000, 0, 0, 0, 1'b0, 0, 0, 0, 1};
      vecs[2] = '{1'b0, 6'h3F, 8'd2, 8'b0000_0001, 0, 0, 1, 1'b1, 3, 4, 1, 2};
      vecs[3] = '{1'b0, 6'h3E, 8'd2, 8'b0000_0010, 0, 0, 2, 1'b0, 3, 4, 1, 2};
      vecs[4] = '{1'b0, 6'h3E, 8'd4, 8'b0000_1111, 0, 0, 2, 1'b1, 3, 4, 1, 2};
      vecs[5] = '{1'b0, 6'h10, 8'd5, 8'b0000_1101, 0, 2, 2, 1'b1, 3, 4, 1, 1};
      vecs[6] = '{1'b0, 6'h20, 8'd1, 8'b0000_0001, 0, 0, 1, 1'b0, 3, 4, 1, 2};
      vecs[7] = '{1'b1, 6'h2A, 8'd2, 8'b0000_0001, 5, 0, 2, 1'b0, 7, 9, 3, 3};

      sel          = 1'b0;
      prog_reset_n = 1'b0;
      cmd_valid    = 1'b0;
      cmd_addr     = '0;
      cmd_len      = '0;
      bit_valid    = 1'b0;
      bit_data     = 1'b0;
      abort        = 1'b0;

      repeat (3) @(negedge prog_clk);
      checkOutput("reset_enable", a_enable, 0);
      checkOutput("reset_busy", a_busy, 0);
      checkOutput("reset_done", a_done, 0);
      checkOutput("reset_err", a_err, 0);
      checkOutput("reset_cmd_ready", a_cmd_ready, 0);
      checkOutput("reset_bit_ready", a_bit_ready, 0);
      checkOutput("reset_address", a_address, 0);
      prog_reset_n = 1'b1;
      @(negedge prog_clk);
      checkOutput("cmd_ready_after_reset", a_cmd_ready, 1);

      for (int i = 0; i < 8; i++) begin
         $display("[TB] vector %0d addr=0x%0h len=%0d", i, vecs[i].addr, vecs[i].len);
         applyStimulus(vecs[i]);
      end

      $display("[TB] reset during STROBE");
      sel = 1'b0;
      @(negedge prog_clk);
      cmd_valid = 1'b1;
      cmd_addr  = 6'h08;
      cmd_len   = 8'd3;
      bit_data  = 1'b1;
      bit_valid = 1'b1;
      seen      = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge prog_clk);
         cmd_valid = 1'b0;
         if (a_enable) seen = 1;
      end
      checkOutput("reached_strobe_before_reset", seen, 1);
      prog_reset_n = 1'b0;
      @(negedge prog_clk);
      checkOutput("midreset_enable", a_enable, 0);
      checkOutput("midreset_busy", a_busy, 0);
      checkOutput("midreset_done", a_done, 0);
      checkOutput("midreset_err", a_err, 0);
      checkOutput("midreset_cmd_ready", a_cmd_ready, 0);
      prog_reset_n = 1'b1;
      bit_valid    = 1'b0;
      @(negedge prog_clk);
      checkOutput("postreset_cmd_ready", a_cmd_ready, 1);
      checkOutput("postreset_address", a_address, 0);
      checkOutput("postreset_data_in", a_data_in, 0);
      applyStimulus(vecs[0]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cb_config_write_sequencer.md
Name: cb_config_write_sequencer

Overview:
- Drives the decoder-addressed configuration port of a connection block (enable / address / data_in) from a command-plus-bitstream interface.
- Accepts a burst command (start address, bit count), then consumes configuration bits one at a time.
- Issues one timed enable strobe per bit, auto-incrementing the address.
- Sits between the tile configuration loader and each cby/cbx configuration port.

Parameters:
- ADDR_W, 6, width of the configuration address; upper field selects the memory via the decoder, lower field selects the bit.
- LEN_W, 8, width of the burst length field.
- SETUP_CYCLES, 1, cycles address/data are stable before enable rises; 0 skips the SETUP state.
- STROBE_CYCLES, 1, cycles enable is high; must be ≥1.
- HOLD_CYCLES, 1, cycles address/data are held after enable falls; 0 skips the HOLD state.

Ports:
- prog_clk  in  1  configuration clock; all logic on its rising edge.
- prog_reset_n  in  1  synchronous, active-low reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  sequencer accepts a command.
- cmd_addr  in  ADDR_W  start address.
- cmd_len  in  LEN_W  number of bits to write.
- bit_valid  in  1  configuration bit valid.
- bit_ready  out  1  sequencer accepts a bit.
- bit_data  in  1  configuration bit value.
- abort  in  1  terminate current burst.
- enable  out  1  to connection-block decoder enable.
- address  out  ADDR_W  to connection-block address.
- data_in  out  1  to connection-block data_in.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  one-cycle pulse, coincident with done, on abort or address overflow.

Behaviour:
- Reset (prog_reset_n=0 sampled at edge): state=IDLE; enable, address, data_in, busy, done, err, cmd_ready, bit_ready all 0. Reset mid-strobe drops enable on that edge.
- Handshakes: transfer when valid && ready on the same edge. cmd_ready=1 only in IDLE with no reset. bit_ready=1 only in WAIT_BIT.
- IDLE: on cmd transfer, latch addr_q=cmd_addr and rem_q=cmd_len.
  - cmd_len==0: next cycle done=1, err=0; stay IDLE; no strobe.
  - Otherwise go to WAIT_BIT with busy=1.
- WAIT_BIT: on bit transfer, drive address=addr_q and data_in=bit_data (registered, next cycle); go to SETUP, or to STROBE if SETUP_CYCLES==0.
- SETUP: hold for SETUP_CYCLES cycles; enable=0.
- STROBE: enable=1 for exactly STROBE_CYCLES cycles; address and data_in stable throughout.
- HOLD: enable=0 for HOLD_CYCLES cycles; address and data_in still held.
- End of HOLD (or end of STROBE if HOLD_CYCLES==0): rem_q-=1.
  - rem_q now 0: done=1 next cycle, go IDLE, busy=0.
  - addr_q==2^ADDR_W-1 and rem_q≠0: overflow; done=1, err=1, go IDLE; no wrap, no further strobe.
  - Otherwise addr_q+=1 and go WAIT_BIT.
- address and data_in keep their last value in IDLE/WAIT_BIT (no glitching); enable only ever high in STROBE.
- Per-bit latency with bit_valid held high: 1 + SETUP_CYCLES + STROBE_CYCLES + HOLD_CYCLES cycles (4 at defaults). A single-bit burst gives done 1 cycle after the final HOLD.
- abort in any non-IDLE state: next edge enable=0, state=IDLE, done=1, err=1. A partially strobed bit counts as unwritten. abort in IDLE is ignored, and a coincident cmd transfer takes priority.
- cmd_valid while busy: not accepted (cmd_ready=0). bit_valid outside WAIT_BIT: not accepted.
- Phase counter width: $clog2(max(SETUP,STROBE,HOLD)+1). rem_q width LEN_W; no underflow possible.

Decomposition:
- Shared package cb_cfg_pkg: state enum (IDLE, WAIT_BIT, SETUP, STROBE, HOLD), address/length typedefs sized from ADDR_W/LEN_W, default timing constants.
- One natural sub-module: cb_cfg_phase_timer, a loadable down-counter reporting expiry, reused for SETUP/STROBE/HOLD.

Test Plan:
- Defaults; cmd_addr=0x18, len=3, bits 1,0,1 back-to-back → three enable pulses, 1 cycle each, 4 cycles apart; addresses 0x18,0x19,0x1A with data 1,0,1; done 1 cycle after last HOLD; err=0.
- len=0 → done=1 next cycle, err=0, no enable pulse, cmd_ready back to 1.
- cmd_addr=0x3F, len=2 → one strobe at 0x3F, then done=1, err=1; address stays 0x3F.
- Abort asserted during STROBE of bit 2 of a len=5 burst → enable 0 next cycle, done=err=1, IDLE, new cmd accepted.
- SETUP=0, STROBE=3, HOLD=0, len=2 with bit_valid gapped by 5 cycles → enable high exactly 3 cycles per bit; address stable while enable=1; bit_ready high only in WAIT_BIT.
- prog_reset_n low for 1 cycle mid-STROBE → enable, busy, done, err all 0 at that edge; subsequent cmd behaves as fresh.
